// File: rtl/sdp_mrdma_ig_req_gen_pkg.sv
// ---------------------------------------------------------------------------
// sdp_mrdma_ig_req_gen_pkg
// Shared SDP MRDMA definitions: atom geometry, default request grouping,
// read-request payload field offsets, request-generator state encoding and
// the chunk-size helper used to split a line into aligned read requests.
// ---------------------------------------------------------------------------
package sdp_mrdma_ig_req_gen_pkg;

    // One atom is 32 bytes; request addresses are atom aligned.
    localparam int unsigned ATOM_BYTES        = 32;
    localparam int unsigned ATOM_SHIFT        = 5;
    localparam int unsigned MAX_ATOMS_DEFAULT = 8;

    // rd_req_pd layout: {size[14:0], addr[63:0]}
    localparam int unsigned PD_ADDR_LSB = 0;
    localparam int unsigned PD_ADDR_MSB = 63;
    localparam int unsigned PD_SIZE_LSB = 64;
    localparam int unsigned PD_SIZE_MSB = 78;
    localparam int unsigned PD_WIDTH    = 79;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mrdma_ig_state_e;

    // Atoms in the next request: the remaining atoms of the line, clipped so
    // the request stops at the next max_atoms-aligned atom boundary.
    // atom_lsb carries address bits [18:5]; max_atoms is a power of 2.
    function automatic logic [13:0] calc_chunk(
        input logic [13:0] atoms_left,
        input logic [13:0] atom_lsb,
        input logic [13:0] max_atoms
    );
        logic [13:0] offset;
        logic [13:0] room;
        offset = atom_lsb & (max_atoms - 14'd1);
        room   = max_atoms - offset;
        calc_chunk = (atoms_left < room) ? atoms_left : room;
    endfunction

endpackage

// File: rtl/sdp_mrdma_ig_req_gen.sv
// ---------------------------------------------------------------------------
// sdp_mrdma_ig_req_gen
// Walks a 2-D surface (height+1 lines of width+1 atoms, lines cfg_line_stride
// bytes apart) and emits atom-aligned read requests that never cross a
// MAX_ATOMS-atom aligned boundary.
//
// Ports
//   nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//   op_load          : start pulse, sampled in IDLE only
//   cfg_base_addr    : surface base byte address (bits[4:0] = 0)
//   cfg_width        : atoms per line minus 1
//   cfg_height       : lines minus 1
//   cfg_line_stride  : bytes between line starts
//   rd_req_valid/ready/pd : request handshake, pd = {size-1, addr}
//   op_busy          : operation in progress (REQ and DONE)
//   op_done          : one-cycle completion pulse
// ---------------------------------------------------------------------------
module sdp_mrdma_ig_req_gen
    import sdp_mrdma_ig_req_gen_pkg::*;
#(
    parameter int unsigned MAX_ATOMS = MAX_ATOMS_DEFAULT
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rstn,
    input  logic                 op_load,
    input  logic [63:0]          cfg_base_addr,
    input  logic [12:0]          cfg_width,
    input  logic [12:0]          cfg_height,
    input  logic [31:0]          cfg_line_stride,
    output logic                 rd_req_valid,
    input  logic                 rd_req_ready,
    output logic [PD_WIDTH-1:0]  rd_req_pd,
    output logic                 op_busy,
    output logic                 op_done
);

    localparam logic [13:0] MAX_ATOMS_W = 14'(MAX_ATOMS);

    mrdma_ig_state_e state_r;
    mrdma_ig_state_e state_s;

    logic [31:0]         stride_r;
    logic [13:0]         line_atoms_r;   // atoms per line (1..8192)
    logic [63:0]         line_addr_r;    // start of the current line
    logic [12:0]         lines_left_r;   // lines still to start after this one
    logic [63:0]         cur_addr_r;     // address of the next chunk in line
    logic [13:0]         remain_r;       // atoms left in line after current req
    logic                valid_r;
    logic [PD_WIDTH-1:0] pd_r;
    logic                busy_r;
    logic                done_r;

    logic                issue_s;        // load a new request into the output flops
    logic                xfer_s;
    logic [63:0]         req_addr_s;
    logic [13:0]         req_left_s;
    logic [63:0]         line_addr_s;
    logic [12:0]         lines_left_s;
    logic [13:0]         chunk_s;
    logic [14:0]         size_s;

    assign xfer_s = valid_r & rd_req_ready;

    // State register.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and selection of the next request to present.
    always_comb begin
        state_s      = state_r;
        issue_s      = 1'b0;
        req_addr_s   = cur_addr_r;
        req_left_s   = remain_r;
        line_addr_s  = line_addr_r;
        lines_left_s = lines_left_r;
        case (state_r)
            ST_IDLE: begin
                if (op_load) begin
                    state_s      = ST_REQ;
                    issue_s      = 1'b1;
                    req_addr_s   = cfg_base_addr;
                    req_left_s   = {1'b0, cfg_width} + 14'd1;
                    line_addr_s  = cfg_base_addr;
                    lines_left_s = cfg_height;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (xfer_s) begin
                    if (remain_r != 14'd0) begin
                        issue_s = 1'b1;
                    end else if (lines_left_r != 13'd0) begin
                        issue_s      = 1'b1;
                        line_addr_s  = line_addr_r + {32'd0, stride_r};
                        req_addr_s   = line_addr_s;
                        req_left_s   = line_atoms_r;
                        lines_left_s = lines_left_r - 13'd1;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign chunk_s = calc_chunk(req_left_s, req_addr_s[18:5], MAX_ATOMS_W);
    assign size_s  = {1'b0, chunk_s} - 15'd1;

    // Captured configuration and walk counters.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            stride_r     <= 32'd0;
            line_atoms_r <= 14'd0;
            line_addr_r  <= 64'd0;
            lines_left_r <= 13'd0;
            cur_addr_r   <= 64'd0;
            remain_r     <= 14'd0;
        end else begin
            if ((state_r == ST_IDLE) && op_load) begin
                stride_r     <= cfg_line_stride;
                line_atoms_r <= {1'b0, cfg_width} + 14'd1;
            end else begin
                stride_r     <= stride_r;
                line_atoms_r <= line_atoms_r;
            end
            line_addr_r  <= line_addr_s;
            lines_left_r <= lines_left_s;
            if (issue_s) begin
                cur_addr_r <= req_addr_s + {45'd0, chunk_s, 5'd0};
                remain_r   <= req_left_s - chunk_s;
            end else begin
                cur_addr_r <= cur_addr_r;
                remain_r   <= remain_r;
            end
        end
    end

    // Output request flops: pd only changes when a new request is issued,
    // which happens only in IDLE or on a transfer, so it is stable while stalled.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            valid_r <= 1'b0;
            pd_r    <= {PD_WIDTH{1'b0}};
        end else if (issue_s) begin
            valid_r <= 1'b1;
            pd_r    <= {size_s, req_addr_s};
        end else if (xfer_s) begin
            valid_r <= 1'b0;
            pd_r    <= pd_r;
        end else begin
            valid_r <= valid_r;
            pd_r    <= pd_r;
        end
    end

    // Status flops aligned with the state register.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
            done_r <= (state_s == ST_DONE);
        end
    end

    assign rd_req_valid = valid_r;
    assign rd_req_pd    = pd_r;
    assign op_busy      = busy_r;
    assign op_done      = done_r;

endmodule

// File: tb/tb_sdp_mrdma_ig_req_gen.sv
module tb_sdp_mrdma_ig_req_gen;

    logic        clk;
    logic        rstn;
    logic        op_load;
    logic [63:0] base;
    logic [12:0] width;
    logic [12:0] height;
    logic [31:0] stride;
    logic        valid;
    logic        ready;
    logic [78:0] pd;
    logic        busy;
    logic        done;

    int total;
    int bad;

    sdp_mrdma_ig_req_gen dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .op_load         (op_load),
        .cfg_base_addr   (base),
        .cfg_width       (width),
        .cfg_height      (height),
        .cfg_line_stride (stride),
        .rd_req_valid    (valid),
        .rd_req_ready    (ready),
        .rd_req_pd       (pd),
        .op_busy         (busy),
        .op_done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0]       base;
        logic [12:0]       width;
        logic [12:0]       height;
        logic [31:0]       stride;
        logic [2:0]        n;
        logic [3:0][63:0]  addr;
        logic [3:0][14:0]  size;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [78:0] act, input logic [78:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start an operation; returns with the first request visible.
    task automatic start(input logic [63:0] b, input logic [12:0] w,
                         input logic [12:0] h, input logic [31:0] s);
        base = b; width = w; height = h; stride = s;
        op_load = 1'b1;
        tick();
        op_load = 1'b0;
        // scramble cfg: must already be captured
        base = 64'hDEAD_BEEF_0000_0AE0; width = 13'd3; height = 13'd5; stride = 32'h40;
        chk("busy_after_load", {78'd0, busy}, 79'd1);
    endtask

    task automatic run_vec(input vec_t v);
        start(v.base, v.width, v.height, v.stride);
        for (int i = 0; i < 4; i++) begin
            if (i < int'(v.n)) begin
                chk("req_valid", {78'd0, valid}, 79'd1);
                chk("req_pd", pd, {v.size[i], v.addr[i]});
                op_load = (i == 0) ? 1'b1 : 1'b0;   // ignored outside IDLE
                tick();
                op_load = 1'b0;
            end
        end
        chk("done_pulse", {76'd0, done, busy, valid}, {76'd0, 3'b110});
        tick();
        chk("after_done", {76'd0, done, busy, valid}, 79'd0);
    endtask

    initial begin
        total = 0; bad = 0;
        rstn = 1'b0; op_load = 1'b0; ready = 1'b1;
        base = 64'd0; width = 13'd0; height = 13'd0; stride = 32'd0;

        vecs[0] = '{64'h1000_0000, 13'd4, 13'd0, 32'h0, 3'd1,
                    {64'd0, 64'd0, 64'd0, 64'h1000_0000}, {15'd0, 15'd0, 15'd0, 15'd4}};
        vecs[1] = '{64'h10C0, 13'd4, 13'd0, 32'h0, 3'd2,
                    {64'd0, 64'd0, 64'h1100, 64'h10C0}, {15'd0, 15'd0, 15'd2, 15'd1}};
        vecs[2] = '{64'h0, 13'd7, 13'd2, 32'h400, 3'd3,
                    {64'd0, 64'h800, 64'h400, 64'h0}, {15'd0, 15'd7, 15'd7, 15'd7}};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FF00, 13'd0, 13'd1, 32'h100, 3'd2,
                    {64'd0, 64'd0, 64'h0, 64'hFFFF_FFFF_FFFF_FF00}, {15'd0, 15'd0, 15'd0, 15'd0}};
        vecs[4] = '{64'h0, 13'd20, 13'd0, 32'h0, 3'd3,
                    {64'd0, 64'h200, 64'h100, 64'h0}, {15'd0, 15'd4, 15'd7, 15'd7}};
        vecs[5] = '{64'h60, 13'd2, 13'd1, 32'h40, 3'd2,
                    {64'd0, 64'd0, 64'hA0, 64'h60}, {15'd0, 15'd0, 15'd2, 15'd2}};
        vecs[6] = '{64'hE0, 13'd2, 13'd0, 32'h0, 3'd2,
                    {64'd0, 64'd0, 64'h100, 64'hE0}, {15'd0, 15'd0, 15'd1, 15'd0}};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {76'd0, valid, busy, done}, 79'd0);
        chk("reset_pd", pd, 79'd0);
        rstn = 1'b1;

        for (int k = 0; k < 7; k++) begin
            run_vec(vecs[k]);
        end

        // Stall: ready low 5 cycles at each request, pd must hold.
        ready = 1'b0;
        start(64'h0, 13'd20, 13'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            logic [78:0] exp_pd;
            exp_pd = (i == 0) ? {15'd7, 64'h0} : (i == 1) ? {15'd7, 64'h100} : {15'd4, 64'h200};
            for (int c = 0; c < 5; c++) begin
                chk("stall_valid", {78'd0, valid}, 79'd1);
                chk("stall_pd", pd, exp_pd);
                tick();
            end
            chk("stall_pd_xfer", pd, exp_pd);
            ready = 1'b1;
            tick();
            ready = 1'b0;
        end
        chk("stall_done", {76'd0, done, busy, valid}, {76'd0, 3'b110});
        tick();
        ready = 1'b1;

        // Reset during the line walk, then restart right after release.
        start(64'h0, 13'd7, 13'd2, 32'h400);
        tick();
        chk("pre_reset_req2", pd, {15'd7, 64'h400});
        tick();
        rstn = 1'b0;
        #1;
        chk("mid_reset_outputs", {76'd0, valid, busy, done}, 79'd0);
        chk("mid_reset_pd", pd, 79'd0);
        rstn = 1'b1;
        start(64'h0, 13'd7, 13'd2, 32'h400);
        chk("restart_pd", pd, {15'd7, 64'h0});
        tick();
        tick();
        tick();
        chk("restart_done", {76'd0, done, busy, valid}, {76'd0, 3'b110});
        tick();

        // Widest line: 8192 atoms from atom 1 -> 7 + 1023*8 + 1 = 1025 requests.
        begin
            int n;
            logic [78:0] last_pd;
            n = 0;
            last_pd = 79'd0;
            start(64'h20, 13'd8191, 13'd0, 32'h0);
            chk("wide_first", pd, {15'd6, 64'h20});
            while (valid && n < 2000) begin
                last_pd = pd;
                n++;
                tick();
            end
            chk("wide_count", 79'(n), 79'd1025);
            chk("wide_last", last_pd, {15'd0, 64'h40000});
            chk("wide_done", {78'd0, done}, 79'd1);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
